// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the word-address helper.
package lsu_pkg;

  // RV32I funct3 encodings for loads and stores.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller states. Exported on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Clear the byte offset so the memory port only ever sees word addresses.
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bus bundle between the core, the LSU and the data memory.
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid && req_ready; a memory request transfers on a rising edge where
// mem_req && mem_gnt, and the LSU holds every mem_* output stable while
// mem_req is high without gnt. mem_rvalid and resp_valid are single-cycle
// pulses with no back-pressure.
interface lsu_if;
  // core -> LSU request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // LSU -> memory
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  // LSU -> core response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // LSU side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output resp_valid, resp_rdata, resp_err
  );

  // Environment side: the core plus the data memory.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load extraction with sign/zero extension, and the misalign/illegal check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        we_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        err_o
);

  logic [31:0] shifted;
  logic        misalign;
  logic        illegal;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = ld_word_i >> {addr_lo_i, 3'b000};

  // Misalignment depends on width only; the unsigned variants share it.
  always_comb begin
    misalign = 1'b0;
    case (funct3_i[1:0])
      2'b01:   misalign = addr_lo_i[0];
      2'b10:   misalign = |addr_lo_i;
      default: misalign = 1'b0;
    endcase
  end

  // Stores have no unsigned variants; loads accept BU/HU as well.
  always_comb begin
    if (we_i) begin
      illegal = !(funct3_i == F3_B || funct3_i == F3_H || funct3_i == F3_W);
    end else begin
      illegal = !(funct3_i == F3_B  || funct3_i == F3_H || funct3_i == F3_W ||
                  funct3_i == F3_BU || funct3_i == F3_HU);
    end
  end

  assign err_o = misalign | illegal;

  // Byte enables and replicated write data; loads reuse the same enables.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      2'b10: begin
        be_o    = 4'b1111;
        wdata_o = st_data_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = 32'h0;
      end
    endcase
  end

  // Extract and extend the load result. A legal word load has offset 0, so
  // the shifted word equals the raw word.
  always_comb begin
    ld_data_o = 32'h0;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data_o = shifted;
      F3_BU:   ld_data_o = {24'h0, shifted[7:0]};
      F3_HU:   ld_data_o = {16'h0, shifted[15:0]};
      default: ld_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single outstanding access, word-addressed memory port
// with byte enables, registered one-cycle response.
module lsu
  import lsu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  lsu_if.slave       bus,
  output lsu_state_e state_o
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        idle;
  logic        accept;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic        al_we;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_ld;
  logic        al_err;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && bus.req_valid;

  // The aligner sees the live request while idle (formatting and error
  // check at accept) and the captured request afterwards (load extraction).
  assign al_funct3  = idle ? bus.req_funct3    : funct3_q;
  assign al_addr_lo = idle ? bus.req_addr[1:0] : addr_lo_q;
  assign al_we      = idle ? bus.req_we        : we_q;

  lsu_align u_align (
    .funct3_i  (al_funct3),
    .addr_lo_i (al_addr_lo),
    .we_i      (al_we),
    .st_data_i (bus.req_wdata),
    .ld_word_i (bus.mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .ld_data_o (al_ld),
    .err_o     (al_err)
  );

  // Next-state and datapath capture for the controller.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    addr_lo_d = addr_lo_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d      = bus.req_we;
          funct3_d  = bus.req_funct3;
          addr_lo_d = bus.req_addr[1:0];
          addr_d    = word_addr(bus.req_addr);
          be_d      = al_be;
          wdata_d   = bus.req_we ? al_wdata : 32'h0;
          rdata_d   = 32'h0;
          err_d     = al_err;
          // Faulting accesses skip memory and answer next cycle.
          state_d   = al_err ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          state_d = we_q ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = al_ld;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Response fields only live for the one pulse cycle.
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured request registers; reset abandons any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      addr_q    <= 32'h0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode from registered state so they drop with async reset;
  // memory fields are zero whenever no request is presented.
  assign bus.req_ready  = idle;
  assign bus.mem_req    = (state_q == ST_REQ);
  assign bus.mem_we     = bus.mem_req & we_q;
  assign bus.mem_addr   = bus.mem_req ? addr_q  : 32'h0;
  assign bus.mem_be     = bus.mem_req ? be_q    : 4'b0000;
  assign bus.mem_wdata  = bus.mem_req ? wdata_q : 32'h0;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU: driver tasks issue operations and push the
// expected {err, rdata} into a queue; a negedge monitor pops and compares.
module tb_lsu;
  import lsu_pkg::*;

  logic       clk;
  logic       rst_n;
  lsu_state_e state;
  lsu_if      bus();

  int n_chk = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  lsu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("resp_err", bus.resp_err, e[32]);
          chk("resp_rdata", bus.resp_rdata, e[31:0]);
        end
      end else begin
        chk("resp_idle_zero", {bus.resp_err, bus.resp_rdata}, 33'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic exp_err, input logic [31:0] exp_rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    if (exp_err) begin
      chk({tag, "_no_mem_req"}, bus.mem_req, 0);
      chk({tag, "_err_latency"}, bus.resp_valid, 1);
    end else begin
      for (int k = 0; k <= gnt_dly; k++) begin
        chk({tag, "_mem_req"}, bus.mem_req, 1);
        chk({tag, "_mem_we"}, bus.mem_we, we);
        chk({tag, "_mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_mem_be"}, bus.mem_be, exp_be);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
        chk({tag, "_busy"}, bus.req_ready, 0);
        bus.mem_gnt = (k == gnt_dly);
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      if (!we) begin
        for (int k = 0; k <= rv_dly; k++) begin
          chk({tag, "_wait_no_req"}, bus.mem_req, 0);
          chk({tag, "_wait_no_resp"}, bus.resp_valid, 0);
          bus.mem_rvalid = (k == rv_dly);
          bus.mem_rdata  = (k == rv_dly) ? rdata : 32'h5A5A_5A5A;
          @(negedge clk);
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
      end
      chk({tag, "_resp_latency"}, bus.resp_valid, 1);
    end
  endtask

  // Start a word load and pull reset while it sits in REQ or WAIT.
  task automatic reset_mid(input string tag, input bit in_wait);
    @(negedge clk);
    chk({tag, "_ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h0000_0080;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({tag, "_mem_req"}, bus.mem_req, 1);
    if (in_wait) begin
      bus.mem_gnt = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      chk({tag, "_in_wait"}, state, ST_WAIT);
    end
    #2 rst_n = 1'b0;
    #1;
    chk({tag, "_rst_mem_req"}, bus.mem_req, 0);
    chk({tag, "_rst_resp"}, bus.resp_valid, 0);
    chk({tag, "_rst_ready"}, bus.req_ready, 1);
    chk({tag, "_rst_state"}, state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    // Late data for the abandoned load must not produce a response.
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1111_2222;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    chk({tag, "_post_ready"}, bus.req_ready, 1);
    chk({tag, "_post_resp"}, bus.resp_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_state", state, ST_IDLE);
    chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 0);

    //     tag     we  f3     addr          wdata         gd rd rdata         err exp_rdata     be       exp_wdata
    do_op("sb",    1, F3_B,  32'h0000_1003, 32'h0000_00A5, 0, 0, 32'h0,         0, 32'h0,         4'b1000, 32'hA5A5_A5A5);
    do_op("lh",    0, F3_H,  32'h0000_2002, 32'h0,         0, 0, 32'h8001_1234, 0, 32'hFFFF_8001, 4'b1100, 32'h0);
    do_op("lhu",   0, F3_HU, 32'h0000_2002, 32'h0,         0, 0, 32'h8001_1234, 0, 32'h0000_8001, 4'b1100, 32'h0);
    do_op("lb",    0, F3_B,  32'h0000_0001, 32'h0,         0, 0, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0010, 32'h0);
    do_op("lw",    0, F3_W,  32'h0000_0000, 32'h0,         0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
    do_op("lw_mis",0, F3_W,  32'h0000_0006, 32'h0,         0, 0, 32'h0,         1, 32'h0,         4'b0000, 32'h0);
    do_op("sh_mis",1, F3_H,  32'h0000_0001, 32'h0000_BEEF, 0, 0, 32'h0,         1, 32'h0,         4'b0000, 32'h0);
    do_op("sw_stl",1, F3_W,  32'h0000_0100, 32'h1234_5678, 3, 0, 32'h0,         0, 32'h0,         4'b1111, 32'h1234_5678);
    do_op("s_ill", 1, 3'b100,32'h0000_0010, 32'h0000_0077, 0, 0, 32'h0,         1, 32'h0,         4'b0000, 32'h0);
    do_op("l_ill", 0, 3'b011,32'h0000_0010, 32'h0,         0, 0, 32'h0,         1, 32'h0,         4'b0000, 32'h0);
    do_op("lb_neg",0, F3_B,  32'h0000_0003, 32'h0,         0, 2, 32'h80FF_FFFF, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    do_op("lbu",   0, F3_BU, 32'h0000_0002, 32'h0,         1, 0, 32'h00AB_0000, 0, 32'h0000_00AB, 4'b0100, 32'h0);
    do_op("sh_hi", 1, F3_H,  32'h0000_0002, 32'hFFFF_BEEF, 1, 0, 32'h0,         0, 32'h0,         4'b1100, 32'hBEEF_BEEF);
    do_op("lhu_lo",0, F3_HU, 32'h0000_0000, 32'h0,         0, 0, 32'h1234_F00D, 0, 32'h0000_F00D, 4'b0011, 32'h0);

    // Stray load data while idle is ignored.
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    chk("stray_ready", bus.req_ready, 1);
    chk("stray_state", state, ST_IDLE);

    reset_mid("rst_wait", 1'b1);
    do_op("lw_after", 0, F3_W, 32'h0000_0040, 32'h0, 0, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b1111, 32'h0);
    reset_mid("rst_req", 1'b0);
    do_op("sb_after", 1, F3_B, 32'h0000_0041, 32'h0000_003C, 0, 0, 32'h0, 0, 32'h0, 4'b0010, 32'h3C3C_3C3C);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RISC-V core. It sits directly downstream of the ALU and takes the ALU result as the effective address. It handles a single outstanding load or store and drives a word-addressed data-memory port with byte enables. For loads it extracts, sign- or zero-extends and returns the requested byte, halfword or word.

## Interface
Parameters:
- none; datapath fixed at 32 bits, memory word 32 bits, 4 byte lanes.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  core presents a memory operation.
- req_ready  out  1  LSU idle and accepting; transfer when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  effective address (ALU sum output).
- req_wdata  in  32  store data (rs2), least-significant bits used.
- mem_req  out  1  memory request valid.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_we  out  1  write request.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  32  load data word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3, qualified by resp_valid.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - REQ: mem_req=1.
  - WAIT: waiting for load data.
  - RESP: resp_valid=1.
- Accept in IDLE. Register we, funct3, addr[1:0], the aligned address, and formatted be/wdata.
- Error check at accept:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - Store funct3 ∉ {000,001,010] or load funct3 ∉ {000,001,010,100,101} is illegal.
  - On error: IDLE→RESP with resp_err=1. No memory access.
- Otherwise IDLE→REQ.
- REQ: mem_req, mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt.
  - Store + gnt → RESP.
  - Load + gnt → WAIT.
- WAIT: on mem_rvalid, capture and extract the data, then → RESP. mem_rvalid is ignored in every other state.
- RESP: one cycle, → IDLE.
- Store formatting:
  - SB: be = 1<<addr[1:0], wdata = {4{b}}.
  - SH: be = 0011 (addr[1]=0) or 1100, wdata = {2{h}}.
  - SW: be = 1111.
- Load extraction:
  - Shift rdata right by 8·addr[1:0].
  - Take 8 or 16 bits and sign-extend (B/H) or zero-extend (BU/HU). W passes through.
- Loads drive mem_be to the same pattern as stores. mem_wdata is don't-care, driven 0.

## Timing
- Reset values: state IDLE, req_ready=1, and all other outputs 0.
- Reset mid-transaction abandons the operation. mem_req and resp_valid drop asynchronously, and no response is produced.
- Store latency with gnt in the first REQ cycle: accept at cycle 0, mem_req at cycle 1, resp_valid at cycle 2.
- Load latency with gnt at cycle 1 and rvalid at cycle 2: resp_valid at cycle 3.
- Error latency: resp_valid at cycle 1.
- Gnt stall of N cycles adds N cycles; rvalid delay adds its own delay.
- req_ready=0 from the cycle after accept until RESP completes. A back-to-back request is accepted at the earliest in the cycle after resp_valid.
- resp_rdata and resp_err are registered and valid only while resp_valid=1; they return to 0 afterwards.

## Structure
- Package lsu_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum (IDLE, REQ, WAIT, RESP).
- Sub-module lsu_align, purely combinational:
  - inputs: funct3, addr[1:0], store data, load word.
  - outputs: be, lane-aligned wdata, extended load data, misalign/illegal flag.
- lsu top holds the FSM and registers.

## Test plan
- SB, addr 0x1003, wdata 0x000000A5, gnt immediate → mem_addr 0x1000, be 1000, mem_wdata 0xA5A5A5A5; resp_valid at cycle 2, err 0.
- LH, addr 0x2002, mem_rdata 0x8001_1234 → resp_rdata 0xFFFF8001. LHU at the same address → 0x00008001.
- LB, addr 0x0001, rdata 0x0000_7F00 → 0x0000007F. LW, addr 0x0000 → full word unchanged.
- LW at 0x0006 or SH at 0x0001 → resp_err=1 at cycle 1, mem_req never asserted.
- gnt withheld 3 cycles → mem_* outputs stable throughout and req_ready=0; response follows gnt by 1 cycle (store). A stray mem_rvalid in IDLE is ignored.
- rst_n asserted while in WAIT → mem_req and resp_valid 0 immediately; after release, the LSU is IDLE with req_ready=1 and the next load completes normally.
